// File: rtl/encoder_ctrl.sv
// Sequences the 5x5-lane encoder datapath through load, ROUNDS compute passes and store, then pulses done.
// Strobes are decoded combinationally from state and stall; a stall freezes state and both counters.
module encoder_ctrl #(
  parameter int LANES  = 25,
  parameter int ROUNDS = 24,
  parameter int LW     = 5,
  parameter int RW     = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic          ready,
  output logic [LW-1:0] lane_idx,
  output logic [RW-1:0] round_idx,
  output logic          mem_rd,
  output logic          stage_en,
  output logic          mem_wr,
  output logic          last_lane,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [LW-1:0] LANE_MAX  = LW'(LANES - 1);
  localparam logic [RW-1:0] ROUND_MAX = RW'(ROUNDS - 1);

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] lane_nxt;
  logic [RW-1:0] round_nxt;
  logic [LW-1:0] lane_step;

  assign last_lane = (lane_idx == LANE_MAX);
  // Lane counter wraps to 0 after the last lane so it never leaves 0..LANES-1.
  assign lane_step = last_lane ? '0 : lane_idx + LW'(1);

  always_comb begin
    state_nxt = state;
    lane_nxt  = lane_idx;
    round_nxt = round_idx;
    ready     = 1'b0;
    mem_rd    = 1'b0;
    stage_en  = 1'b0;
    mem_wr    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = LOAD;
          lane_nxt  = '0;
          round_nxt = '0;
        end
      end
      LOAD: begin
        mem_rd = !stall;
        if (!stall) begin
          lane_nxt = lane_step;
          if (last_lane) state_nxt = ROUND;
        end
      end
      ROUND: begin
        stage_en = !stall;
        if (!stall) begin
          lane_nxt = lane_step;
          if (last_lane) begin
            if (round_idx == ROUND_MAX) begin
              round_nxt = '0;
              state_nxt = STORE;
            end else begin
              round_nxt = round_idx + RW'(1);
            end
          end
        end
      end
      STORE: begin
        mem_wr = !stall;
        if (!stall) begin
          lane_nxt = lane_step;
          if (last_lane) state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        lane_nxt  = '0;
        round_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lane_idx  <= '0;
      round_idx <= '0;
    end else begin
      state     <= state_nxt;
      lane_idx  <= lane_nxt;
      round_idx <= round_nxt;
    end
  end

endmodule

// File: tb/tb_encoder_ctrl.sv
// Scoreboard bench for encoder_ctrl: per-cycle expected outputs are queued from the phase/lane/round
// walk, then popped and compared against the default-size and a 3-lane/1-round instance.
module tb_encoder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, stall, start_s, stall_s;
  logic       ready, mem_rd, stage_en, mem_wr, last_lane, done;
  logic [4:0] lane_idx, round_idx;
  logic       ready_s, mem_rd_s, stage_en_s, mem_wr_s, last_lane_s, done_s;
  logic [1:0] lane_idx_s;
  logic [0:0] round_idx_s;

  encoder_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .ready(ready),
    .lane_idx(lane_idx), .round_idx(round_idx), .mem_rd(mem_rd), .stage_en(stage_en),
    .mem_wr(mem_wr), .last_lane(last_lane), .done(done)
  );

  encoder_ctrl #(.LANES(3), .ROUNDS(1), .LW(2), .RW(1)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .stall(stall_s), .ready(ready_s),
    .lane_idx(lane_idx_s), .round_idx(round_idx_s), .mem_rd(mem_rd_s), .stage_en(stage_en_s),
    .mem_wr(mem_wr_s), .last_lane(last_lane_s), .done(done_s)
  );

  typedef struct packed {
    logic       ready;
    logic       rd;
    logic       en;
    logic       wr;
    logic       done;
    logic       last;
    logic [4:0] lane;
    logic [4:0] rnd;
  } obs_t;

  typedef struct packed {
    logic rst;
    logic start;
    logic stall;
    obs_t exp;
  } step_t;

  step_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Scenario knobs: stall insertion points, a busy-time start poke, and an abort point.
  int st_ph[3], st_r[3], st_l[3], st_n[3];
  int poke_ph, poke_r, poke_l;
  bit poke_done;
  int ab_ph, ab_r, ab_l;

  task clear_knobs();
    for (int i = 0; i < 3; i++) begin
      st_ph[i] = -1; st_r[i] = 0; st_l[i] = 0; st_n[i] = 0;
    end
    poke_ph = -1; poke_r = 0; poke_l = 0; poke_done = 1'b0;
    ab_ph = -1; ab_r = 0; ab_l = 0;
  endtask

  function automatic obs_t mk(bit rdy, bit rd, bit en, bit wr, bit dn, bit lst, int lane, int rnd);
    obs_t o;
    o.ready = rdy; o.rd = rd; o.en = en; o.wr = wr; o.done = dn; o.last = lst;
    o.lane = 5'(lane); o.rnd = 5'(rnd);
    return o;
  endfunction

  task push(bit r, bit s, bit st, obs_t e);
    step_t t;
    t.rst = r; t.start = s; t.stall = st; t.exp = e;
    sb.push_back(t);
  endtask

  // Expected trace of one run: the IDLE cycle that accepts start through the first IDLE after DONE.
  task gen(int lanes, int rounds);
    obs_t idle_o, o;
    int   nr, rr, ns;
    bit   lst, pk, ab;
    idle_o = mk(1, 0, 0, 0, 0, 0, 0, 0);
    push(0, 1, 0, idle_o);
    for (int ph = 1; ph <= 3; ph++) begin
      nr = (ph == 2) ? rounds : 1;
      for (int r = 0; r < nr; r++) begin
        for (int l = 0; l < lanes; l++) begin
          rr  = (ph == 2) ? r : 0;
          lst = (l == lanes - 1);
          ns  = 0;
          for (int i = 0; i < 3; i++)
            if (st_ph[i] == ph && st_r[i] == rr && st_l[i] == l) ns = st_n[i];
          for (int i = 0; i < ns; i++) push(0, 0, 1, mk(0, 0, 0, 0, 0, lst, l, rr));
          o  = mk(0, ph == 1, ph == 2, ph == 3, 0, lst, l, rr);
          pk = (poke_ph == ph && poke_r == rr && poke_l == l);
          ab = (ab_ph == ph && ab_r == rr && ab_l == l);
          push(ab, pk, 0, o);
          if (ab) begin
            push(0, 0, 0, idle_o);
            return;
          end
        end
      end
    end
    push(0, poke_done, 0, mk(0, 0, 0, 0, 1, 0, 0, 0));
    push(0, 0, 0, idle_o);
  endtask

  function automatic obs_t obs_big();
    return mk(ready, mem_rd, stage_en, mem_wr, done, last_lane, int'(lane_idx), int'(round_idx));
  endfunction

  function automatic obs_t obs_small();
    return mk(ready_s, mem_rd_s, stage_en_s, mem_wr_s, done_s, last_lane_s,
              int'(lane_idx_s), int'(round_idx_s));
  endfunction

  // Drains the scoreboard one cycle per entry; entered and left at posedge+1.
  task run(bit sel, string name, int exp_done_off, int exp_dones);
    step_t t;
    obs_t  o;
    int    cyc, start_cyc, done_cyc, dones;
    cyc = 0; start_cyc = -1; done_cyc = -1; dones = 0;
    while (sb.size() > 0) begin
      t   = sb.pop_front();
      rst = t.rst;
      if (sel) begin start_s = t.start; stall_s = t.stall; end
      else     begin start   = t.start; stall   = t.stall; end
      #1;
      o = sel ? obs_small() : obs_big();
      n_checks++;
      if (o !== t.exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: outputs %h, expected %h", name, cyc, o, t.exp);
      end
      if (t.start && !t.rst && o.ready && start_cyc < 0) start_cyc = cyc;
      if (o.done === 1'b1) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 0; start = 0; stall = 0; start_s = 0; stall_s = 0;
    n_checks++;
    if (dones !== exp_dones) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d, expected %0d", name, dones, exp_dones);
    end
    if (exp_done_off >= 0) begin
      n_checks++;
      if (done_cyc - start_cyc !== exp_done_off) begin
        n_fail++;
        $display("FAIL %s done_latency: got %0d, expected %0d", name, done_cyc - start_cyc, exp_done_off);
      end
    end
  endtask

  task test_reset();
    obs_t idle_o;
    idle_o = mk(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) push(1, 1, 0, idle_o);
    push(0, 0, 0, idle_o);
    push(0, 0, 0, idle_o);
    run(0, "reset", -1, 0);
  endtask

  task test_full_run();
    clear_knobs();
    gen(25, 24);
    run(0, "full_run", 651, 1);
  endtask

  task test_stall();
    clear_knobs();
    st_ph[0] = 1; st_r[0] = 0;  st_l[0] = 24; st_n[0] = 4;
    st_ph[1] = 2; st_r[1] = 23; st_l[1] = 24; st_n[1] = 4;
    st_ph[2] = 3; st_r[2] = 0;  st_l[2] = 0;  st_n[2] = 4;
    gen(25, 24);
    run(0, "stall", 663, 1);
  endtask

  task test_start_busy();
    clear_knobs();
    poke_ph = 2; poke_r = 3; poke_l = 7; poke_done = 1'b1;
    gen(25, 24);
    push(0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
    push(0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
    run(0, "start_busy", 651, 1);
  endtask

  task test_back_to_back();
    clear_knobs();
    gen(25, 24);
    void'(sb.pop_back());
    gen(25, 24);
    run(0, "back_to_back", 651, 2);
  endtask

  task test_reset_mid();
    clear_knobs();
    ab_ph = 2; ab_r = 5; ab_l = 12;
    gen(25, 24);
    push(0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0));
    run(0, "reset_mid", -1, 0);
    clear_knobs();
    gen(25, 24);
    run(0, "after_reset", 651, 1);
  endtask

  task test_small();
    clear_knobs();
    gen(3, 1);
    run(1, "small", 10, 1);
  endtask

  initial begin
    rst = 1; start = 1; stall = 0; start_s = 0; stall_s = 0;
    clear_knobs();
    @(posedge clk);
    #1;
    test_reset();
    test_full_run();
    test_stall();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
